rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
- Shares one 32-bit single-transfer memory bus between the instruction-fetch port and the load/store data port of the core.
- Registered grant FSM. Data requests have priority, with an anti-starvation limit for fetch.
- Streaming re-arbitration happens on every ack. A per-transfer timeout watchdog returns an error instead of hanging the pipeline.
- Sits between the core (fetch unit, memory stage) and the external bus/SRAM interconnect.

Parameters:
- IADDR_SPACE_BITS, 16, width of the instruction address; zero-extended onto the bus.
- ADDR_BITS, 32, width of the data address and the bus address.
- DATA_STREAK_MAX, 4, maximum consecutive data grants while fetch is pending; range 1..15.
- TIMEOUT_CYCLES, 255, cycles without ack before an error is returned; range 2..65535.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous active-high reset.
- i_ibus_addr  in  IADDR_SPACE_BITS  fetch address.
- i_ibus_cyc  in  1  fetch request, held until ack/err.
- o_ibus_data  out  32  fetch read data.
- o_ibus_ack  out  1  fetch transfer done.
- o_ibus_err  out  1  fetch timeout.
- i_dbus_addr  in  ADDR_BITS  data address.
- i_dbus_cyc  in  1  data request.
- i_dbus_we  in  1  write enable.
- i_dbus_sel  in  4  byte lanes.
- i_dbus_wdata  in  32  write data.
- o_dbus_data  out  32  read data.
- o_dbus_ack  out  1  data transfer done.
- o_dbus_err  out  1  data timeout.
- o_bus_addr  out  ADDR_BITS  bus address.
- o_bus_cyc  out  1  bus cycle active.
- o_bus_we  out  1  bus write.
- o_bus_sel  out  4  bus byte lanes.
- o_bus_wdata  out  32  bus write data.
- i_bus_data  in  32  bus read data.
- i_bus_ack  in  1  bus transfer done.

Behaviour:
- Reset: state IDLE, streak counter 0, timeout counter 0. Every output is 0 while i_reset is high; the bus cycle drops immediately (asynchronously), including mid-transfer.
- FSM states are IDLE, GNT_I and GNT_D. The bus mux is combinational from the registered state.
  - IDLE drives all bus outputs to 0.
  - GNT_I drives addr = zero-extended i_ibus_addr, we = 0, sel = 4'hF, wdata = 0, cyc = i_ibus_cyc.
  - GNT_D passes all i_dbus_* fields through.
- Arbitration function, evaluated in IDLE and on each completion edge (ack or err):
  - data wins if i_dbus_cyc && !(i_ibus_cyc && streak == DATA_STREAK_MAX);
  - otherwise fetch wins if i_ibus_cyc;
  - otherwise the next state is IDLE.
- Latency: a request asserted in cycle N gives o_bus_cyc in N+1. The earliest ack is N+1, passed combinationally: o_x_ack = i_bus_ack && granted && i_x_cyc.
- Read data: o_ibus_data and o_dbus_data both equal i_bus_data unconditionally. Requesters must qualify it with their own ack.
- Back-to-back transfers: on an ack edge the FSM re-arbitrates with no IDLE bubble. A continuously held i_ibus_cyc streams one fetch per ack.
- Streak counter:
  - increments (saturating) on each data grant made while i_ibus_cyc = 1;
  - resets to 0 on a fetch grant, or whenever i_ibus_cyc = 0 at a grant decision.
- Requester abort: the granted requester drops cyc before ack. The bus cyc drops in the same cycle, any i_bus_ack that cycle is swallowed, and the FSM goes to IDLE at the next edge.
- Timeout counter:
  - clears on every grant;
  - increments each granted cycle without i_bus_ack;
  - at TIMEOUT_CYCLES-1 with no ack, pulses o_x_err for one cycle (no ack) to the granted requester, drops the bus cyc the next cycle, and re-arbitrates.
- Ack and timeout in the same cycle: ack wins, no err.
- i_bus_ack while IDLE is ignored.
- Ack and err are never both high. At most one requester sees ack/err per cycle.

Test Plan:
- Fetch only, i_ibus_cyc held, slave acks every cycle from N+1 → o_ibus_ack continuous from N+1; o_bus_addr follows i_ibus_addr (e.g. 0x0010 gives 0x00000010); sel = F, we = 0.
- Simultaneous i_ibus_cyc and i_dbus_cyc (write, addr 0x8000_0004, sel 4'h3, wdata 0xDEAD_BEEF) → data granted first with fields passed exactly; fetch granted on the ack edge.
- Data held continuously with fetch pending, DATA_STREAK_MAX = 4 → grant sequence D, D, D, D, I, D…; streak reads 0 after the I grant.
- Slave never acks, TIMEOUT_CYCLES = 8 → o_dbus_err is a single pulse 8 cycles after grant; o_bus_cyc is 0 the next cycle; a pending fetch is granted next.
- Fetch drops cyc mid-transfer while i_bus_ack arrives the same cycle → o_ibus_ack stays 0, FSM returns to IDLE. i_reset asserted mid-transfer → o_bus_cyc is 0 in the same cycle and all outputs are 0.

Source files
------------

// File: rtl/rv_mem_arbiter.sv
// Two-port arbiter sharing one single-transfer memory bus between instruction fetch and load/store.
// Data has priority, fetch gets an anti-starvation slot, and a watchdog turns a hung transfer into an error.
module rv_mem_arbiter #(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int ADDR_BITS        = 32,
  parameter int DATA_STREAK_MAX  = 4,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [IADDR_SPACE_BITS-1:0] i_ibus_addr,
  input  logic                        i_ibus_cyc,
  output logic [31:0]                 o_ibus_data,
  output logic                        o_ibus_ack,
  output logic                        o_ibus_err,
  input  logic [ADDR_BITS-1:0]        i_dbus_addr,
  input  logic                        i_dbus_cyc,
  input  logic                        i_dbus_we,
  input  logic [3:0]                  i_dbus_sel,
  input  logic [31:0]                 i_dbus_wdata,
  output logic [31:0]                 o_dbus_data,
  output logic                        o_dbus_ack,
  output logic                        o_dbus_err,
  output logic [ADDR_BITS-1:0]        o_bus_addr,
  output logic                        o_bus_cyc,
  output logic                        o_bus_we,
  output logic [3:0]                  o_bus_sel,
  output logic [31:0]                 o_bus_wdata,
  input  logic [31:0]                 i_bus_data,
  input  logic                        i_bus_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [3:0]  STREAK_MAX = 4'(DATA_STREAK_MAX);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_streak, w_streak_nxt;
  logic [15:0] r_tcnt, w_tcnt_nxt;
  logic        w_gnt_i, w_gnt_d, w_req, w_ack, w_tmo, w_pick_d, w_pick_i;

  function automatic logic [3:0] streak_sat_inc(input logic [3:0] v);
    return (v >= STREAK_MAX) ? STREAK_MAX : v + 4'd1;
  endfunction

  assign w_gnt_i  = (r_state == GNT_I);
  assign w_gnt_d  = (r_state == GNT_D);
  // A granted requester that has dropped cyc is treated as an abort: no ack, no err.
  assign w_req    = (w_gnt_i && i_ibus_cyc) || (w_gnt_d && i_dbus_cyc);
  assign w_ack    = w_req && i_bus_ack;
  assign w_tmo    = w_req && !i_bus_ack && (r_tcnt >= TMO_LAST);
  assign w_pick_d = i_dbus_cyc && !(i_ibus_cyc && (r_streak == STREAK_MAX));
  assign w_pick_i = !w_pick_d && i_ibus_cyc;

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_tcnt_nxt   = r_tcnt;
    if (r_state == IDLE || w_ack) begin
      w_tcnt_nxt = '0;
      if (w_pick_d) begin
        w_state_nxt  = GNT_D;
        w_streak_nxt = i_ibus_cyc ? streak_sat_inc(r_streak) : 4'd0;
      end else if (w_pick_i) begin
        w_state_nxt  = GNT_I;
        w_streak_nxt = '0;
      end else begin
        w_state_nxt  = IDLE;
        w_streak_nxt = '0;
      end
    end else if (!w_req || w_tmo) begin
      // Abort or watchdog expiry: release the bus for one cycle, then arbitrate from IDLE.
      w_state_nxt = IDLE;
      w_tcnt_nxt  = '0;
    end else begin
      w_tcnt_nxt = r_tcnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_tcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      r_tcnt   <= w_tcnt_nxt;
    end
  end

  // Outputs are forced low combinationally during reset so the bus cycle drops mid-transfer.
  always_comb begin
    o_ibus_data = '0;
    o_ibus_ack  = 1'b0;
    o_ibus_err  = 1'b0;
    o_dbus_data = '0;
    o_dbus_ack  = 1'b0;
    o_dbus_err  = 1'b0;
    o_bus_addr  = '0;
    o_bus_cyc   = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_sel   = '0;
    o_bus_wdata = '0;
    if (!i_reset) begin
      o_ibus_data = i_bus_data;
      o_dbus_data = i_bus_data;
      o_ibus_ack  = w_gnt_i && w_ack;
      o_ibus_err  = w_gnt_i && w_tmo;
      o_dbus_ack  = w_gnt_d && w_ack;
      o_dbus_err  = w_gnt_d && w_tmo;
      case (r_state)
        GNT_I: begin
          o_bus_addr  = ADDR_BITS'(i_ibus_addr);
          o_bus_cyc   = i_ibus_cyc;
          o_bus_sel   = 4'hF;
        end
        GNT_D: begin
          o_bus_addr  = i_dbus_addr;
          o_bus_cyc   = i_dbus_cyc;
          o_bus_we    = i_dbus_we;
          o_bus_sel   = i_dbus_sel;
          o_bus_wdata = i_dbus_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Scoreboard bench for rv_mem_arbiter: requester models push expected completions, a monitor pops and compares.
module tb_rv_mem_arbiter;

  localparam logic [31:0] K = 32'h5A5A_0F0F;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_ibus_addr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_data;
  logic        o_ibus_ack, o_ibus_err;
  logic [31:0] i_dbus_addr;
  logic        i_dbus_cyc, i_dbus_we;
  logic [3:0]  i_dbus_sel;
  logic [31:0] i_dbus_wdata, o_dbus_data;
  logic        o_dbus_ack, o_dbus_err;
  logic [31:0] o_bus_addr;
  logic        o_bus_cyc, o_bus_we;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_wdata, i_bus_data;
  logic        i_bus_ack;

  logic ack_en, ack_force, ack_en_nxt, ack_force_nxt;

  // Slave model: acks the active cycle when enabled, read data derived from the address.
  assign i_bus_ack  = ack_force | (ack_en & o_bus_cyc);
  assign i_bus_data = o_bus_addr ^ K;

  always #5 i_clk = ~i_clk;

  rv_mem_arbiter #(
    .IADDR_SPACE_BITS(16),
    .ADDR_BITS(32),
    .DATA_STREAK_MAX(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_ibus_addr(i_ibus_addr), .i_ibus_cyc(i_ibus_cyc),
    .o_ibus_data(o_ibus_data), .o_ibus_ack(o_ibus_ack), .o_ibus_err(o_ibus_err),
    .i_dbus_addr(i_dbus_addr), .i_dbus_cyc(i_dbus_cyc), .i_dbus_we(i_dbus_we),
    .i_dbus_sel(i_dbus_sel), .i_dbus_wdata(i_dbus_wdata),
    .o_dbus_data(o_dbus_data), .o_dbus_ack(o_dbus_ack), .o_dbus_err(o_dbus_err),
    .o_bus_addr(o_bus_addr), .o_bus_cyc(o_bus_cyc), .o_bus_we(o_bus_we),
    .o_bus_sel(o_bus_sel), .o_bus_wdata(o_bus_wdata),
    .i_bus_data(i_bus_data), .i_bus_ack(i_bus_ack)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          hold;
    logic        err;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  req_t ireq_q[$], dreq_q[$];
  exp_t iexp_q[$], dexp_q[$];
  byte  gseq[$];
  bit   i_act, d_act, i_done, d_done, probe_streak;
  int   i_hold, d_hold;
  int   n_checks, n_errors;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic req_t mk_req(input logic [31:0] a, input logic we, input logic [3:0] sel,
                                  input logic [31:0] wd, input int hold, input logic err);
    req_t r;
    r.addr = a; r.we = we; r.sel = sel; r.wdata = wd; r.hold = hold; r.err = err;
    return r;
  endfunction

  function automatic logic any_out();
    return |{o_ibus_data, o_ibus_ack, o_ibus_err, o_dbus_data, o_dbus_ack, o_dbus_err,
             o_bus_addr, o_bus_cyc, o_bus_we, o_bus_sel, o_bus_wdata};
  endfunction

  function automatic bit all_idle();
    return ireq_q.size() == 0 && dreq_q.size() == 0 && iexp_q.size() == 0 &&
           dexp_q.size() == 0 && !i_act && !d_act;
  endfunction

  // Requesters hold cyc until ack/err (or for 'hold' cycles when modelling an abort).
  task automatic drive_next();
    req_t r;
    ack_en    = ack_en_nxt;
    ack_force = ack_force_nxt;
    if (i_act) begin
      if (i_done) i_act = 1'b0;
      else if (i_hold > 0) begin
        i_hold--;
        if (i_hold == 0) i_act = 1'b0;
      end
    end
    i_done = 1'b0;
    if (!i_act && ireq_q.size() != 0) begin
      r = ireq_q.pop_front();
      i_ibus_addr = r.addr[15:0];
      i_hold = r.hold;
      i_act = 1'b1;
      if (r.hold == 0) iexp_q.push_back('{err: r.err, data: {16'h0, r.addr[15:0]} ^ K});
    end
    i_ibus_cyc = i_act;
    if (d_act) begin
      if (d_done) d_act = 1'b0;
      else if (d_hold > 0) begin
        d_hold--;
        if (d_hold == 0) d_act = 1'b0;
      end
    end
    d_done = 1'b0;
    if (!d_act && dreq_q.size() != 0) begin
      r = dreq_q.pop_front();
      i_dbus_addr = r.addr; i_dbus_we = r.we; i_dbus_sel = r.sel; i_dbus_wdata = r.wdata;
      d_hold = r.hold;
      d_act = 1'b1;
      if (r.hold == 0) dexp_q.push_back('{err: r.err, data: r.addr ^ K});
    end
    i_dbus_cyc = d_act;
  endtask

  task automatic monitor();
    exp_t e;
    if (o_ibus_ack || o_ibus_err) begin
      check("ibus_ack_err_excl", o_ibus_ack & o_ibus_err, 0);
      check("ibus_dbus_excl", o_dbus_ack | o_dbus_err, 0);
      if (iexp_q.size() == 0) check("ibus_unexpected", 1, 0);
      else begin
        e = iexp_q.pop_front();
        check("ibus_err", o_ibus_err, e.err);
        if (!e.err) check("ibus_data", o_ibus_data, e.data);
      end
      if (o_ibus_ack) gseq.push_back(8'h49);
      if (o_ibus_ack && probe_streak) check("streak_after_i", dut.r_streak, 0);
      i_done = 1'b1;
    end
    if (o_dbus_ack || o_dbus_err) begin
      check("dbus_ack_err_excl", o_dbus_ack & o_dbus_err, 0);
      if (dexp_q.size() == 0) check("dbus_unexpected", 1, 0);
      else begin
        e = dexp_q.pop_front();
        check("dbus_err", o_dbus_err, e.err);
        if (!e.err) check("dbus_data", o_dbus_data, e.data);
      end
      if (o_dbus_ack) gseq.push_back(8'h44);
      d_done = 1'b1;
    end
  endtask

  // One clock: drive just after the rising edge, observe on the falling edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
    drive_next();
    @(negedge i_clk);
    monitor();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!all_idle() && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check("drain_bound", 1, 0);
    repeat (3) tick();
  endtask

  initial begin : main
    string exp_s;
    int    errk;
    n_checks = 0; n_errors = 0;
    i_reset = 1'b1;
    i_ibus_addr = '0; i_ibus_cyc = 1'b0;
    i_dbus_addr = '0; i_dbus_cyc = 1'b0; i_dbus_we = 1'b0; i_dbus_sel = '0; i_dbus_wdata = '0;
    ack_en = 1'b0; ack_force = 1'b0; ack_en_nxt = 1'b0; ack_force_nxt = 1'b1;
    i_act = 0; d_act = 0; i_done = 0; d_done = 0; i_hold = 0; d_hold = 0; probe_streak = 0;

    // Reset: everything low, including read-data passthrough and a stray ack.
    repeat (2) tick();
    check("rst_outs_zero", any_out(), 0);
    check("rst_streak", dut.r_streak, 0);
    check("rst_tcnt", dut.r_tcnt, 0);
    i_reset = 1'b0;
    tick();
    check("idle_ack_ignored", o_ibus_ack | o_dbus_ack, 0);
    check("idle_bus_cyc", o_bus_cyc, 0);
    ack_force_nxt = 1'b0;
    ack_en_nxt = 1'b1;
    drain();

    // Fetch streaming with one ack per cycle.
    ireq_q.push_back(mk_req(32'h0010, 0, 4'h0, 0, 0, 0));
    ireq_q.push_back(mk_req(32'hFFF0, 0, 4'h0, 0, 0, 0));
    ireq_q.push_back(mk_req(32'h0018, 0, 4'h0, 0, 0, 0));
    ireq_q.push_back(mk_req(32'h001C, 0, 4'h0, 0, 0, 0));
    tick();
    check("fetch_latency_cyc", o_bus_cyc, 0);
    tick();
    check("fetch_ack0", o_ibus_ack, 1);
    check("fetch_addr0", o_bus_addr, 32'h0000_0010);
    check("fetch_sel", o_bus_sel, 4'hF);
    check("fetch_we", o_bus_we, 0);
    check("fetch_wdata", o_bus_wdata, 0);
    tick();
    check("fetch_ack1", o_ibus_ack, 1);
    check("fetch_addr_zext", o_bus_addr, 32'h0000_FFF0);
    tick();
    check("fetch_ack2", o_ibus_ack, 1);
    tick();
    check("fetch_ack3", o_ibus_ack, 1);
    drain();

    // Simultaneous requests: data first, fields passed through, fetch follows.
    gseq.delete();
    ireq_q.push_back(mk_req(32'h0020, 0, 4'h0, 0, 0, 0));
    dreq_q.push_back(mk_req(32'h8000_0004, 1, 4'h3, 32'hDEAD_BEEF, 0, 0));
    tick();
    tick();
    check("both_dack", o_dbus_ack, 1);
    check("both_iack_low", o_ibus_ack, 0);
    check("both_addr", o_bus_addr, 32'h8000_0004);
    check("both_we", o_bus_we, 1);
    check("both_sel", o_bus_sel, 4'h3);
    check("both_wdata", o_bus_wdata, 32'hDEAD_BEEF);
    drain();
    check("both_order_len", gseq.size(), 2);
    check("both_order_0", gseq.size() > 0 ? gseq[0] : 8'h0, 8'h44);
    check("both_order_1", gseq.size() > 1 ? gseq[1] : 8'h0, 8'h49);

    // Anti-starvation: data streams while one fetch waits.
    gseq.delete();
    probe_streak = 1'b1;
    ireq_q.push_back(mk_req(32'h0100, 0, 4'h0, 0, 0, 0));
    for (int k = 0; k < 7; k++) dreq_q.push_back(mk_req(32'h1000 + 4 * k, 0, 4'hF, 0, 0, 0));
    drain();
    probe_streak = 1'b0;
    exp_s = "DDDDIDDD";
    check("streak_len", gseq.size(), exp_s.len());
    for (int k = 0; k < exp_s.len(); k++)
      check($sformatf("streak_seq_%0d", k), k < gseq.size() ? gseq[k] : 8'h0, exp_s[k]);

    // Watchdog: slave silent, data errors out, pending fetch then served.
    ack_en_nxt = 1'b0;
    dreq_q.push_back(mk_req(32'h0000_3000, 0, 4'hF, 0, 0, 1));
    ireq_q.push_back(mk_req(32'h0200, 0, 4'h0, 0, 0, 0));
    tick();
    errk = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (o_dbus_err) begin
        errk = k;
        break;
      end
    end
    check("tmo_latency", errk, 8);
    ack_en_nxt = 1'b1;
    tick();
    check("tmo_bus_dropped", o_bus_cyc, 0);
    check("tmo_err_single", o_dbus_err, 0);
    tick();
    check("tmo_fetch_next", o_ibus_ack, 1);
    drain();

    // Ack arriving in the last watchdog cycle wins over the error.
    ack_en_nxt = 1'b0;
    dreq_q.push_back(mk_req(32'h0000_4000, 0, 4'hF, 0, 0, 0));
    repeat (8) tick();
    check("tmo_edge_no_early_err", o_dbus_err, 0);
    ack_en_nxt = 1'b1;
    tick();
    check("tmo_edge_ack", o_dbus_ack, 1);
    check("tmo_edge_no_err", o_dbus_err, 0);
    drain();

    // Fetch aborts in the same cycle the slave acks.
    ack_en_nxt = 1'b0;
    ireq_q.push_back(mk_req(32'h0300, 0, 4'h0, 0, 2, 0));
    tick();
    tick();
    check("abort_granted", o_bus_cyc, 1);
    ack_force_nxt = 1'b1;
    tick();
    check("abort_ack_swallowed", o_ibus_ack, 0);
    check("abort_bus_cyc", o_bus_cyc, 0);
    tick();
    check("abort_idle", dut.r_state, 0);
    check("abort_idle_ack", o_ibus_ack | o_dbus_ack, 0);
    ack_force_nxt = 1'b0;
    drain();

    // Reset asserted mid-transfer.
    dreq_q.push_back(mk_req(32'h0000_5000, 0, 4'hF, 0, 0, 1));
    tick();
    tick();
    check("rstmid_pre_cyc", o_bus_cyc, 1);
    i_reset = 1'b1;
    #1;
    check("rstmid_cyc_now", o_bus_cyc, 0);
    check("rstmid_outs_zero", any_out(), 0);
    dexp_q.delete();
    d_act = 1'b0;
    d_done = 1'b0;
    i_dbus_cyc = 1'b0;
    tick();
    check("rstmid_state", dut.r_state, 0);
    check("rstmid_tcnt", dut.r_tcnt, 0);
    i_reset = 1'b0;
    tick();
    check("rstmid_after_cyc", o_bus_cyc, 0);
    drain();

    check("ibus_left", iexp_q.size(), 0);
    check("dbus_left", dexp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
